// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one two-channel acquisition (pre-trigger fill,
// trigger wait, post-trigger fill) and then reads ch A and ch B back as one
// merged rdy/ack/eof word stream for the host TX path.
module capture_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  n_pre,
    input  logic [CNT_WIDTH-1:0]  n_samples,
    input  logic                  trigger,
    input  logic                  sample_wr,
    output logic                  wr_en,
    output logic                  rqst_buff_a,
    output logic                  rqst_buff_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  data_rdy_a,
    output logic                  data_ack_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  data_rdy_b,
    output logic                  data_ack_b,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_rdy,
    input  logic                  data_ack,
    output logic                  data_eof,
    output logic                  ch_sel,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = CNT_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PRETRIG   = 4'd1,
        S_WAIT_TRIG = 4'd2,
        S_POSTTRIG  = 4'd3,
        S_REQ_A     = 4'd4,
        S_SEND_A    = 4'd5,
        S_REQ_B     = 4'd6,
        S_SEND_B    = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] pre_q,   pre_d;
    logic [CW-1:0] len_q,   len_d;
    logic [CW-1:0] post_q,  post_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Post-trigger length, saturating at zero when the pre-trigger part
    // already covers the whole frame.
    logic [CW-1:0] post_calc_c;
    always_comb begin
        post_calc_c = '0;
        if (n_samples > n_pre) begin
            post_calc_c = n_samples - n_pre;
        end
    end

    // Counters stop at target-1 and compare there, so a full-scale target
    // (all ones) never needs the counter to wrap.
    logic pre_last_c, post_last_c, len_last_c;
    assign pre_last_c  = (cnt_q == pre_q  - CW'(1));
    assign post_last_c = (cnt_q == post_q - CW'(1));
    assign len_last_c  = (cnt_q == len_q  - CW'(1));

    // State and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            len_q   <= '0;
            post_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            len_q   <= len_d;
            post_q  <= post_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and state-decoded outputs / stream muxes.
    always_comb begin
        logic fire_c;

        state_d     = state_q;
        pre_d       = pre_q;
        len_d       = len_q;
        post_d      = post_q;
        cnt_d       = cnt_q;
        fire_c      = 1'b0;

        wr_en       = 1'b0;
        rqst_buff_a = 1'b0;
        rqst_buff_b = 1'b0;
        data_ack_a  = 1'b0;
        data_ack_b  = 1'b0;
        data_out    = '0;
        data_rdy    = 1'b0;
        data_eof    = 1'b1;
        ch_sel      = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop has no meaning here, so start always wins over it
                if (start && (n_samples != '0)) begin
                    pre_d  = n_pre;
                    len_d  = n_samples;
                    post_d = post_calc_c;
                    cnt_d  = '0;
                    state_d = (n_pre == '0) ? S_WAIT_TRIG : S_PRETRIG;
                end
            end

            S_PRETRIG: begin
                wr_en = 1'b1;
                if (stop) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (sample_wr) begin
                    if (pre_last_c) begin
                        cnt_d   = '0;
                        state_d = S_WAIT_TRIG;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_WAIT_TRIG: begin
                // a sample written in the trigger cycle still belongs to
                // the pre-trigger history and is not counted
                wr_en = 1'b1;
                if (stop) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (trigger) begin
                    cnt_d   = '0;
                    state_d = (post_q == '0) ? S_REQ_A : S_POSTTRIG;
                end
            end

            S_POSTTRIG: begin
                wr_en = 1'b1;
                if (stop) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (sample_wr) begin
                    if (post_last_c) begin
                        cnt_d   = '0;
                        state_d = S_REQ_A;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_REQ_A: begin
                rqst_buff_a = 1'b1;
                data_eof    = 1'b0;
                cnt_d       = '0;
                state_d     = S_SEND_A;
            end

            S_SEND_A: begin
                data_eof   = 1'b0;
                data_out   = data_a;
                data_rdy   = data_rdy_a;
                fire_c     = data_ack & data_rdy_a;
                data_ack_a = fire_c;
                if (fire_c) begin
                    if (len_last_c) begin
                        cnt_d   = '0;
                        state_d = S_REQ_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_REQ_B: begin
                rqst_buff_b = 1'b1;
                data_eof    = 1'b0;
                ch_sel      = 1'b1;
                cnt_d       = '0;
                state_d     = S_SEND_B;
            end

            S_SEND_B: begin
                data_eof   = 1'b0;
                ch_sel     = 1'b1;
                data_out   = data_b;
                data_rdy   = data_rdy_b;
                fire_c     = data_ack & data_rdy_b;
                data_ack_b = fire_c;
                if (fire_c) begin
                    if (len_last_c) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
